mlcd_id_reader: RTL and testbench
=================================

# mlcd_id_reader

Reads the controller ID from the MCU LCD over the Intel 8080 bus before the LCD init and pixel-write logic take over. It sits on the same 16-bit bus as the pixel writer, which receives the resulting `lcd_id`. The block probes four controller families in a fixed order and reports the first match. It drives RD/WR/RS/CS itself and controls the data-bus tristate through an output-enable; the bus is released when it is idle or done.

## Interface
- `WR_LOW`, default 2: clocks WR is held low per command write.
- `WR_HIGH`, default 2: clocks WR is held high after a command write.
- `RD_LOW`, default 8: clocks RD is held low per read.
- `RD_HIGH`, default 8: clocks RD is held high after a read.
- `clk  in  1`: system clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: one-cycle pulse that begins a probe sequence. Ignored while `busy`.
- `mlcd_cs  out  1`: chip select, active low.
- `mlcd_rs  out  1`: 0 = command, 1 = data.
- `mlcd_wr  out  1`: write strobe, active low.
- `mlcd_rd  out  1`: read strobe, active low.
- `mlcd_data_out  out  16`: bus value driven during command writes.
- `mlcd_data_oe  out  1`: 1 = FPGA drives the bus.
- `mlcd_data_in  in  16`: bus value returned by the panel.
- `busy  out  1`: a probe sequence is in progress.
- `id_done  out  1`: level; the sequence has finished. Cleared by the next `start`.
- `id_valid  out  1`: a known controller was found. Meaningful only while `id_done` is high.
- `lcd_id  out  16`: one of 0x9341, 0x5310, 0x5510, 0x1963, or 0x0000 if no match.

## Operation
- Reset values: `mlcd_cs`=1, `mlcd_rs`=1, `mlcd_wr`=1, `mlcd_rd`=1, `mlcd_data_out`=0, `mlcd_data_oe`=0, `busy`=0, `id_done`=0, `id_valid`=0, `lcd_id`=0.
- States:
  - IDLE goes to CMD_L on `start`.
  - CMD_L → CMD_H → RD_L → RD_H.
  - RD_H loops back to RD_L until the word count is reached, then goes to EVAL.
  - EVAL goes to GAP on a miss with probes remaining, and to DONE otherwise.
  - GAP goes to CMD_L for the next probe.
  - DONE goes to CMD_L on `start`.
- Probe order (command, number of read words, match rule; only the low bytes w[n][7:0] are compared):
  - P0: command 0x00D3, 4 words. Match if w2=0x93 and w3=0x41; ID 0x9341.
  - P1: command 0x00D4, 4 words. Match if w2=0x53 and w3=0x10; ID 0x5310.
  - P2: command 0xDB00, 2 words. Match if w1=0x80; ID 0x5510.
  - P3: command 0x00A1, 3 words. Match if w1=0x57 and w2=0x61; ID 0x1963.
  - If no probe matches, `lcd_id`=0x0000 and `id_valid`=0.
- Command write:
  - `mlcd_cs`=0, `mlcd_rs`=0, `mlcd_data_oe`=1, `mlcd_data_out`=command for the whole CMD_L/CMD_H span.
  - `mlcd_wr`=0 during CMD_L only.
- Read:
  - `mlcd_rs`=1, `mlcd_data_oe`=0.
  - `mlcd_rd`=0 during RD_L.
  - `mlcd_data_in` is captured on the clock edge that ends the last RD_L cycle, which is also the edge where RD rises.
- Word storage: 4 × 8-bit registers indexed by a 2-bit word counter. The counter resets to 0 at each CMD_L.
- GAP: 1 cycle with `mlcd_cs`=1 and all strobes high.
- DONE/IDLE: CS, RD and WR high; `mlcd_data_oe`=0.
- Bus-level rule: RD and WR are never low in the same cycle. `mlcd_data_oe` is never 1 while `mlcd_rd`=0.

## Timing
- The edge that samples `start` moves the block to CMD_L. `busy`, `mlcd_cs`=0 and `mlcd_wr`=0 are all visible in the next cycle.
- Duration of a single probe: WR_LOW+WR_HIGH + N·(RD_LOW+RD_HIGH) + 1 (EVAL).
- On a match in EVAL, the next cycle has `busy`=0 and `id_done`=1, with `lcd_id` and `id_valid` updated in that same cycle.
- Defaults, P0 match: `id_done` rises 69 cycles after `busy` rises (4 + 64 + 1).
- Defaults, full miss: 4 probes plus 3 GAP cycles. `id_done` rises 4·4 + 13·16 + 4 + 3 = 231 cycles after `busy` rises.
- `start` while `busy`: ignored, with no effect on state or counters.
- `start` in DONE: `id_done`, `id_valid` and `lcd_id` clear on the next cycle, and the sequence restarts at P0.
- `rst_n` asserted mid-cycle: all outputs return to their reset values immediately (asynchronously). Any half-finished strobe is abandoned.
- Cycle counter width is clog2 of max(WR_LOW, WR_HIGH, RD_LOW, RD_HIGH)+1. The counter loads its phase length at each state entry and counts down.

## Structure
- Shared package `mlcd_pkg`:
  - controller ID constants ID_9341, ID_5310, ID_5510, ID_1963;
  - probe command constants;
  - state enum;
  - per-probe word-count constants.
- Sub-module `mlcd_bus_cycle`: one 8080 write or read cycle.
  - Inputs: `go`, `is_read`, `wdata`.
  - Outputs: `done`, `rdata`, plus the strobes.
  - Timing comes from the four parameters.
- The top level holds the probe index, word registers, match logic and result outputs.

## Test plan
- ILI9341 model returns 0x00, 0x00, 0x93, 0x41 to command 0xD3 → `lcd_id`=0x9341, `id_valid`=1, `id_done` exactly 69 cycles after `busy`, only one command issued.
- NT35510 model answers only command 0xDB00, with 0x00, 0x80 → three commands seen (0xD3, 0xD4, 0xDB00), `lcd_id`=0x5510.
- Bus returns 0xFFFF on every read → all four probes issued, `lcd_id`=0x0000, `id_valid`=0, done at cycle 231.
- `start` pulsed again mid-P1 → no restart and the command sequence is unchanged. `start` in DONE → `id_done` drops and the sequence reruns from P0.
- `rst_n` low while `mlcd_rd`=0 → same-cycle CS/RD/WR=1 and `oe`=0. After release the block sits in IDLE until `start`.
- Assertion throughout all tests: never `mlcd_rd`=0 with `mlcd_data_oe`=1, and never RD and WR low together.

Source files
------------

// File: rtl/mlcd_pkg.sv
// Shared constants, state encodings and probe tables for the MCU LCD controller ID reader.
package mlcd_pkg;

  localparam logic [15:0] ID_9341 = 16'h9341;
  localparam logic [15:0] ID_5310 = 16'h5310;
  localparam logic [15:0] ID_5510 = 16'h5510;
  localparam logic [15:0] ID_1963 = 16'h1963;

  localparam logic [15:0] CMD_P0 = 16'h00D3;
  localparam logic [15:0] CMD_P1 = 16'h00D4;
  localparam logic [15:0] CMD_P2 = 16'hDB00;
  localparam logic [15:0] CMD_P3 = 16'h00A1;

  localparam logic [2:0] WORDS_P0 = 3'd4;
  localparam logic [2:0] WORDS_P1 = 3'd4;
  localparam logic [2:0] WORDS_P2 = 3'd2;
  localparam logic [2:0] WORDS_P3 = 3'd3;

  localparam logic [1:0] LAST_PROBE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD_L, ST_CMD_H, ST_RD_L, ST_RD_H, ST_EVAL, ST_GAP, ST_DONE
  } mlcd_state_t;

  typedef enum logic [1:0] {BC_IDLE, BC_LOW, BC_HIGH} bc_phase_t;

  typedef logic [3:0][7:0] word_bank_t;

  function automatic logic [15:0] probe_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    probe_cmd = CMD_P0;
      2'd1:    probe_cmd = CMD_P1;
      2'd2:    probe_cmd = CMD_P2;
      2'd3:    probe_cmd = CMD_P3;
      default: probe_cmd = CMD_P0;
    endcase
  endfunction

  function automatic logic [2:0] probe_words(input logic [1:0] idx);
    case (idx)
      2'd0:    probe_words = WORDS_P0;
      2'd1:    probe_words = WORDS_P1;
      2'd2:    probe_words = WORDS_P2;
      2'd3:    probe_words = WORDS_P3;
      default: probe_words = WORDS_P0;
    endcase
  endfunction

  function automatic logic [15:0] probe_id(input logic [1:0] idx);
    case (idx)
      2'd0:    probe_id = ID_9341;
      2'd1:    probe_id = ID_5310;
      2'd2:    probe_id = ID_5510;
      2'd3:    probe_id = ID_1963;
      default: probe_id = 16'h0000;
    endcase
  endfunction

  // Only the low byte of each returned word carries ID information.
  function automatic logic probe_match(input logic [1:0] idx, input word_bank_t w);
    case (idx)
      2'd0:    probe_match = (w[2] == 8'h93) && (w[3] == 8'h41);
      2'd1:    probe_match = (w[2] == 8'h53) && (w[3] == 8'h10);
      2'd2:    probe_match = (w[1] == 8'h80);
      2'd3:    probe_match = (w[1] == 8'h57) && (w[2] == 8'h61);
      default: probe_match = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mlcd_id_reader_bus_cycle.sv
// One Intel 8080 command write or data read: strobe-low phase, strobe-high phase, registered bus pins.
module mlcd_bus_cycle
  import mlcd_pkg::*;
#(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2,
  parameter int RD_LOW  = 8,
  parameter int RD_HIGH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        is_read,
  input  logic [15:0] wdata,
  input  logic [15:0] data_in,
  output logic        done,
  output logic        low_done,
  output logic [15:0] rdata,
  output logic        cs,
  output logic        rs,
  output logic        wr,
  output logic        rd,
  output logic [15:0] data_out,
  output logic        data_oe
);

  localparam int MAX_A  = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
  localparam int MAX_B  = (RD_LOW > RD_HIGH) ? RD_LOW : RD_HIGH;
  localparam int MAXLEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW     = $clog2(MAXLEN + 1);

  localparam logic [CW-1:0] WR_LOW_C  = CW'(WR_LOW);
  localparam logic [CW-1:0] WR_HIGH_C = CW'(WR_HIGH);
  localparam logic [CW-1:0] RD_LOW_C  = CW'(RD_LOW);
  localparam logic [CW-1:0] RD_HIGH_C = CW'(RD_HIGH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  bc_phase_t     phase_r;
  logic          read_r;
  logic [CW-1:0] cnt_r;
  logic [15:0]   rdata_r;
  logic          cs_r, rs_r, wr_r, rd_r, oe_r;
  logic [15:0]   dout_r;

  assign low_done = (phase_r == BC_LOW)  && (cnt_r == CNT_ONE);
  assign done     = (phase_r == BC_HIGH) && (cnt_r == CNT_ONE);
  assign rdata    = rdata_r;
  assign cs       = cs_r;
  assign rs       = rs_r;
  assign wr       = wr_r;
  assign rd       = rd_r;
  assign data_out = dout_r;
  assign data_oe  = oe_r;

  // Phase sequencer: a new go may arrive in the final high cycle so cycles chain without gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= BC_IDLE;
      read_r  <= 1'b0;
      cnt_r   <= '0;
      rdata_r <= 16'h0000;
      cs_r    <= 1'b1;
      rs_r    <= 1'b1;
      wr_r    <= 1'b1;
      rd_r    <= 1'b1;
      dout_r  <= 16'h0000;
      oe_r    <= 1'b0;
    end else if (go) begin
      phase_r <= BC_LOW;
      read_r  <= is_read;
      cnt_r   <= is_read ? RD_LOW_C : WR_LOW_C;
      cs_r    <= 1'b0;
      rs_r    <= is_read;
      wr_r    <= is_read;
      rd_r    <= !is_read;
      dout_r  <= is_read ? 16'h0000 : wdata;
      oe_r    <= !is_read;
    end else begin
      case (phase_r)
        BC_LOW: begin
          if (cnt_r == CNT_ONE) begin
            phase_r <= BC_HIGH;
            cnt_r   <= read_r ? RD_HIGH_C : WR_HIGH_C;
            wr_r    <= 1'b1;
            rd_r    <= 1'b1;
            if (read_r) begin
              rdata_r <= data_in;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        BC_HIGH: begin
          if (cnt_r == CNT_ONE) begin
            phase_r <= BC_IDLE;
            cnt_r   <= '0;
            cs_r    <= 1'b1;
            rs_r    <= 1'b1;
            dout_r  <= 16'h0000;
            oe_r    <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        BC_IDLE: begin
          phase_r <= BC_IDLE;
        end
        default: begin
          phase_r <= BC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/mlcd_id_reader.sv
// Probes four LCD controller families over the 8080 bus and reports the first matching controller ID.
module mlcd_id_reader
  import mlcd_pkg::*;
#(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2,
  parameter int RD_LOW  = 8,
  parameter int RD_HIGH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        mlcd_cs,
  output logic        mlcd_rs,
  output logic        mlcd_wr,
  output logic        mlcd_rd,
  output logic [15:0] mlcd_data_out,
  output logic        mlcd_data_oe,
  input  logic [15:0] mlcd_data_in,
  output logic        busy,
  output logic        id_done,
  output logic        id_valid,
  output logic [15:0] lcd_id
);

  mlcd_state_t state_r, state_nx;
  logic [1:0]  probe_r;
  logic [1:0]  wcnt_r;
  word_bank_t  words_r;
  logic        busy_r, id_done_r, id_valid_r;
  logic [15:0] lcd_id_r;

  logic        bc_go_s, bc_is_read_s, bc_done_s, bc_low_done_s;
  logic [15:0] bc_wdata_s, bc_rdata_s;
  logic        eval_match_s;
  logic [1:0]  last_word_s;

  assign eval_match_s = probe_match(probe_r, words_r);
  assign last_word_s  = 2'(probe_words(probe_r) - 3'd1);

  assign busy     = busy_r;
  assign id_done  = id_done_r;
  assign id_valid = id_valid_r;
  assign lcd_id   = lcd_id_r;

  mlcd_bus_cycle #(
    .WR_LOW (WR_LOW),
    .WR_HIGH(WR_HIGH),
    .RD_LOW (RD_LOW),
    .RD_HIGH(RD_HIGH)
  ) u_bus (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (bc_go_s),
    .is_read (bc_is_read_s),
    .wdata   (bc_wdata_s),
    .data_in (mlcd_data_in),
    .done    (bc_done_s),
    .low_done(bc_low_done_s),
    .rdata   (bc_rdata_s),
    .cs      (mlcd_cs),
    .rs      (mlcd_rs),
    .wr      (mlcd_wr),
    .rd      (mlcd_rd),
    .data_out(mlcd_data_out),
    .data_oe (mlcd_data_oe)
  );

  // Next-state and bus-cycle launch decode.
  always_comb begin
    state_nx     = state_r;
    bc_go_s      = 1'b0;
    bc_is_read_s = 1'b0;
    bc_wdata_s   = 16'h0000;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx   = ST_CMD_L;
          bc_go_s    = 1'b1;
          bc_wdata_s = CMD_P0;
        end else begin
          state_nx = state_r;
        end
      end
      ST_CMD_L: begin
        if (bc_low_done_s) state_nx = ST_CMD_H;
        else               state_nx = ST_CMD_L;
      end
      ST_CMD_H: begin
        if (bc_done_s) begin
          state_nx     = ST_RD_L;
          bc_go_s      = 1'b1;
          bc_is_read_s = 1'b1;
        end else begin
          state_nx = ST_CMD_H;
        end
      end
      ST_RD_L: begin
        if (bc_low_done_s) state_nx = ST_RD_H;
        else               state_nx = ST_RD_L;
      end
      ST_RD_H: begin
        if (bc_done_s && (wcnt_r == last_word_s)) begin
          state_nx = ST_EVAL;
        end else if (bc_done_s) begin
          state_nx     = ST_RD_L;
          bc_go_s      = 1'b1;
          bc_is_read_s = 1'b1;
        end else begin
          state_nx = ST_RD_H;
        end
      end
      ST_EVAL: begin
        if (eval_match_s || (probe_r == LAST_PROBE)) state_nx = ST_DONE;
        else                                         state_nx = ST_GAP;
      end
      ST_GAP: begin
        state_nx   = ST_CMD_L;
        bc_go_s    = 1'b1;
        bc_wdata_s = probe_cmd(probe_r);
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State register, word capture, probe advance and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      probe_r    <= 2'd0;
      wcnt_r     <= 2'd0;
      words_r    <= '0;
      busy_r     <= 1'b0;
      id_done_r  <= 1'b0;
      id_valid_r <= 1'b0;
      lcd_id_r   <= 16'h0000;
    end else begin
      state_r <= state_nx;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            busy_r     <= 1'b1;
            id_done_r  <= 1'b0;
            id_valid_r <= 1'b0;
            lcd_id_r   <= 16'h0000;
            probe_r    <= 2'd0;
            wcnt_r     <= 2'd0;
          end
        end
        ST_GAP: begin
          wcnt_r <= 2'd0;
        end
        ST_RD_H: begin
          if (bc_done_s) begin
            words_r[wcnt_r] <= bc_rdata_s[7:0];
            wcnt_r          <= wcnt_r + 2'd1;
          end
        end
        ST_EVAL: begin
          if (eval_match_s) begin
            busy_r     <= 1'b0;
            id_done_r  <= 1'b1;
            id_valid_r <= 1'b1;
            lcd_id_r   <= probe_id(probe_r);
          end else if (probe_r == LAST_PROBE) begin
            busy_r     <= 1'b0;
            id_done_r  <= 1'b1;
            id_valid_r <= 1'b0;
            lcd_id_r   <= 16'h0000;
          end else begin
            probe_r <= probe_r + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mlcd_id_reader.sv
// Directed bench for mlcd_id_reader with a behavioural panel that answers ID commands per mode.
module tb_mlcd_id_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mlcd_cs, mlcd_rs, mlcd_wr, mlcd_rd, mlcd_data_oe;
  logic [15:0] mlcd_data_out;
  logic [15:0] panel_data = 16'h0000;
  logic        busy, id_done, id_valid;
  logic [15:0] lcd_id;

  int total = 0;
  int bad = 0;
  int viol = 0;
  int mode = 0;
  int rd_idx = 0;
  logic [15:0] cur_cmd = 16'h0000;
  logic [15:0] cmd_log[$];

  always #5 clk = ~clk;

  mlcd_id_reader #(.WR_LOW(2), .WR_HIGH(2), .RD_LOW(8), .RD_HIGH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mlcd_cs      (mlcd_cs),
    .mlcd_rs      (mlcd_rs),
    .mlcd_wr      (mlcd_wr),
    .mlcd_rd      (mlcd_rd),
    .mlcd_data_out(mlcd_data_out),
    .mlcd_data_oe (mlcd_data_oe),
    .mlcd_data_in (panel_data),
    .busy         (busy),
    .id_done      (id_done),
    .id_valid     (id_valid),
    .lcd_id       (lcd_id)
  );

  // Panel answers: mode 0 = ILI9341, mode 1 = NT35510, mode 2 = bus floats high.
  function automatic logic [15:0] resp(input int m, input logic [15:0] c, input int i);
    logic [15:0] r;
    r = 16'h0000;
    if (m == 2) begin
      r = 16'hFFFF;
    end else if (m == 0 && c == 16'h00D3) begin
      case (i)
        0: r = 16'h1200;
        1: r = 16'h3400;
        2: r = 16'hAB93;
        3: r = 16'hCD41;
        default: r = 16'h0000;
      endcase
    end else if (m == 1 && c == 16'hDB00) begin
      case (i)
        0: r = 16'h2200;
        1: r = 16'h5580;
        default: r = 16'h0000;
      endcase
    end
    return r;
  endfunction

  always @(posedge mlcd_wr) begin
    if (!mlcd_cs && !mlcd_rs) begin
      cmd_log.push_back(mlcd_data_out);
      cur_cmd = mlcd_data_out;
      rd_idx = 0;
    end
  end

  always @(negedge mlcd_rd) panel_data = resp(mode, cur_cmd, rd_idx);
  always @(posedge mlcd_rd) rd_idx = rd_idx + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!mlcd_rd && !mlcd_wr) viol = viol + 1;
      if (!mlcd_rd && mlcd_data_oe) viol = viol + 1;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    total++; if ({mlcd_cs, mlcd_rs, mlcd_wr, mlcd_rd} !== 4'b1111) begin bad++; $display("FAIL reset_strobes got=%b want=1111", {mlcd_cs, mlcd_rs, mlcd_wr, mlcd_rd}); end
    total++; if (mlcd_data_out !== 16'h0000 || mlcd_data_oe !== 1'b0) begin bad++; $display("FAIL reset_bus got=%h/%b want=0000/0", mlcd_data_out, mlcd_data_oe); end
    total++; if ({busy, id_done, id_valid} !== 3'b000 || lcd_id !== 16'h0000) begin bad++; $display("FAIL reset_status got=%b id=%h want=000 id=0000", {busy, id_done, id_valid}, lcd_id); end
  endtask

  task automatic test_ili9341();
    int n;
    mode = 0; cmd_log.delete();
    pulse_start();
    total++; if (busy !== 1'b1 || mlcd_cs !== 1'b0 || mlcd_wr !== 1'b0 || mlcd_data_out !== 16'h00D3) begin bad++; $display("FAIL ili_first_cycle got busy=%b cs=%b wr=%b d=%h want 1 0 0 00d3", busy, mlcd_cs, mlcd_wr, mlcd_data_out); end
    n = 0;
    while (!id_done && n < 1000) begin @(negedge clk); n++; end
    total++; if (n !== 69) begin bad++; $display("FAIL ili_latency got=%0d want=69", n); end
    total++; if (lcd_id !== 16'h9341 || id_valid !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ili_result got id=%h v=%b busy=%b want 9341 1 0", lcd_id, id_valid, busy); end
    total++; if (cmd_log.size() !== 1) begin bad++; $display("FAIL ili_cmd_count got=%0d want=1", cmd_log.size()); end
    total++; if (mlcd_data_oe !== 1'b0 || mlcd_cs !== 1'b1) begin bad++; $display("FAIL ili_bus_released got oe=%b cs=%b want 0 1", mlcd_data_oe, mlcd_cs); end
  endtask

  task automatic test_nt35510();
    int n;
    mode = 1; cmd_log.delete();
    pulse_start();
    n = 0;
    while (!id_done && n < 1000) begin @(negedge clk); n++; end
    total++; if (n !== 177) begin bad++; $display("FAIL nt_latency got=%0d want=177", n); end
    total++; if (lcd_id !== 16'h5510 || id_valid !== 1'b1) begin bad++; $display("FAIL nt_result got id=%h v=%b want 5510 1", lcd_id, id_valid); end
    total++; if (cmd_log.size() !== 3) begin bad++; $display("FAIL nt_cmd_count got=%0d want=3", cmd_log.size()); end
    else begin
      total++; if (cmd_log[0] !== 16'h00D3 || cmd_log[1] !== 16'h00D4 || cmd_log[2] !== 16'hDB00) begin bad++; $display("FAIL nt_cmd_order got=%h %h %h want 00d3 00d4 db00", cmd_log[0], cmd_log[1], cmd_log[2]); end
    end
  endtask

  task automatic test_restart_in_done();
    int n;
    mode = 0; cmd_log.delete();
    pulse_start();
    total++; if (id_done !== 1'b0 || id_valid !== 1'b0 || lcd_id !== 16'h0000 || busy !== 1'b1) begin bad++; $display("FAIL restart_clear got done=%b v=%b id=%h busy=%b want 0 0 0000 1", id_done, id_valid, lcd_id, busy); end
    n = 0;
    while (!id_done && n < 1000) begin @(negedge clk); n++; end
    total++; if (n !== 69 || lcd_id !== 16'h9341) begin bad++; $display("FAIL restart_rerun got n=%0d id=%h want 69 9341", n, lcd_id); end
  endtask

  task automatic test_no_match();
    int n;
    mode = 2; cmd_log.delete();
    pulse_start();
    n = 0;
    while (!id_done && n < 1000) begin @(negedge clk); n++; end
    total++; if (n !== 231) begin bad++; $display("FAIL miss_latency got=%0d want=231", n); end
    total++; if (lcd_id !== 16'h0000 || id_valid !== 1'b0) begin bad++; $display("FAIL miss_result got id=%h v=%b want 0000 0", lcd_id, id_valid); end
    total++; if (cmd_log.size() !== 4) begin bad++; $display("FAIL miss_cmd_count got=%0d want=4", cmd_log.size()); end
    else begin
      total++; if (cmd_log[2] !== 16'hDB00 || cmd_log[3] !== 16'h00A1) begin bad++; $display("FAIL miss_cmd_order got=%h %h want db00 00a1", cmd_log[2], cmd_log[3]); end
    end
  endtask

  task automatic test_start_while_busy();
    int n;
    mode = 1; cmd_log.delete();
    pulse_start();
    n = 0;
    while (!id_done && n < 1000) begin
      start = (n == 90) ? 1'b1 : 1'b0;
      @(negedge clk); n++;
    end
    start = 1'b0;
    total++; if (n !== 177 || lcd_id !== 16'h5510) begin bad++; $display("FAIL busy_start got n=%0d id=%h want 177 5510", n, lcd_id); end
    total++; if (cmd_log.size() !== 3) begin bad++; $display("FAIL busy_start_cmds got=%0d want=3", cmd_log.size()); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    mode = 2; cmd_log.delete();
    pulse_start();
    n = 0;
    while (mlcd_rd !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    total++; if (mlcd_rd !== 1'b0) begin bad++; $display("FAIL rst_reach_read got rd=%b want 0", mlcd_rd); end
    rst_n = 1'b0;
    #1;
    total++; if ({mlcd_cs, mlcd_rd, mlcd_wr, mlcd_data_oe} !== 4'b1110) begin bad++; $display("FAIL rst_async got cs/rd/wr/oe=%b want 1110", {mlcd_cs, mlcd_rd, mlcd_wr, mlcd_data_oe}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b want=0", busy); end
    @(negedge clk) rst_n = 1'b1;
    cmd_log.delete();
    repeat (20) @(negedge clk);
    total++; if (busy !== 1'b0 || mlcd_cs !== 1'b1 || cmd_log.size() !== 0) begin bad++; $display("FAIL rst_idle got busy=%b cs=%b cmds=%0d want 0 1 0", busy, mlcd_cs, cmd_log.size()); end
    mode = 0;
    pulse_start();
    n = 0;
    while (!id_done && n < 1000) begin @(negedge clk); n++; end
    total++; if (n !== 69 || lcd_id !== 16'h9341) begin bad++; $display("FAIL rst_recover got n=%0d id=%h want 69 9341", n, lcd_id); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_ili9341();
    test_nt35510();
    test_restart_in_done();
    test_no_match();
    test_start_while_busy();
    test_reset_mid_read();
    total++; if (viol !== 0) begin bad++; $display("FAIL bus_rule got=%0d want=0", viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
